// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//
// Fetch-side conditional-branch direction predictor. A table of 2-bit
// saturating counters, indexed by pc[IDX_BITS+1:2], supplies a combinational
// prediction to fetch. Every accepted prediction is queued in an in-order FIFO
// until the decode-stage branch compare resolves it. Resolution trains the
// counter. A wrong prediction raises a one-cycle flush with the corrected PC,
// bumps the mispredict counter and discards everything still queued (those
// entries were fetched down the wrong path).
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst_n          : synchronous reset, active low
//   fetch_valid    : fetch presents a predecoded conditional branch
//   fetch_pc       : PC of that branch
//   fetch_target   : taken target computed by fetch predecode
//   pred_ready     : unit accepts a prediction this cycle (RUN and FIFO not full)
//   pred_taken     : predicted direction for fetch_pc (combinational)
//   res_valid      : decode resolved the oldest outstanding branch
//   res_taken      : actual direction of that branch
//   flush          : one-cycle mispredict pulse
//   redirect_pc    : corrected fetch PC, valid while flush is high
//   mispredict_cnt : running mispredict total, wraps at 2**32
//   protocol_err   : one-cycle pulse when res_valid arrives with nothing queued
// -----------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int IDX_BITS   = 6,
    parameter int PEND_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_target,
    output logic        pred_ready,
    output logic        pred_taken,
    input  logic        res_valid,
    input  logic        res_taken,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] mispredict_cnt,
    output logic        protocol_err
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int PTR_W   = $clog2(PEND_DEPTH);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]         pc4;
        logic [31:0]         target;
        logic [IDX_BITS-1:0] idx;
        logic                pred;
    } pend_t;

    state_t              state;
    logic [IDX_BITS-1:0] init_idx;

    logic [1:0] counter  [ENTRIES];
    pend_t      fifo_mem [PEND_DEPTH];

    // One extra wrap bit on each pointer distinguishes full from empty.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;

    logic                fifo_empty;
    logic                fifo_full;
    logic [IDX_BITS-1:0] lookup_idx;
    pend_t               head;
    logic [1:0]          head_ctr;
    logic [1:0]          trained_ctr;
    logic                push;
    logic                pop;
    logic                mispredict;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign lookup_idx = fetch_pc[IDX_BITS+1:2];
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign head_ctr   = counter[head.idx];

    // Ready reflects the occupancy before any same-cycle pop, so a full FIFO
    // refuses a push even while its head is being resolved.
    assign pred_ready = (state == ST_RUN) && !fifo_full;

    // Gated outside RUN so an uninitialised table never reaches fetch.
    // Reads the table before this edge's training write, so a same-index
    // lookup and update see the old counter value.
    assign pred_taken = (state == ST_RUN) && counter[lookup_idx][1];

    assign push       = fetch_valid && pred_ready;
    assign pop        = (state == ST_RUN) && res_valid && !fifo_empty;
    assign mispredict = pop && (res_taken != head.pred);

    // Saturating +1 / -1 on the resolved branch's counter.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        trained_ctr = head_ctr;
        if (res_taken) begin
            if (head_ctr != 2'b11) trained_ctr = head_ctr + 2'd1;
        end else begin
            if (head_ctr != 2'b00) trained_ctr = head_ctr - 2'd1;
        end
    end

    // Counter table. INIT walks every entry to weakly-not-taken, so the array
    // itself carries no reset.
    // NOTE: storage arrays are not reset; a per-entry reset would turn RAM-like
    // arrays into wide reset trees, and the INIT sweep already defines them.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT) begin
                counter[init_idx] <= 2'b01;
            end else if (pop) begin
                counter[head.idx] <= trained_ctr;
            end
        end
    end

    // Pending-prediction storage. A push coinciding with a mispredicting pop is
    // on the wrong path and is not written.
    always_ff @(posedge clk) begin
        if (rst_n && push && !mispredict) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= '{
                pc4:    fetch_pc + 32'd4,
                target: fetch_target,
                idx:    lookup_idx,
                pred:   pred_taken
            };
        end
    end

    // Control FSM, FIFO pointers and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_INIT;
            init_idx       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
            protocol_err   <= 1'b0;
        end else begin
            flush        <= 1'b0;
            protocol_err <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == '1) state <= ST_RUN;
                end
                ST_RUN: begin
                    protocol_err <= res_valid && fifo_empty;
                    if (mispredict) begin
                        flush          <= 1'b1;
                        redirect_pc    <= res_taken ? head.target : head.pc4;
                        mispredict_cnt <= mispredict_cnt + 32'd1;
                        wr_ptr         <= '0;
                        rd_ptr         <= '0;
                        state          <= ST_FLUSH;
                    end else begin
                        if (push) wr_ptr <= wr_ptr + 1'b1;
                        if (pop)  rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // flush was raised on entry and drops on this edge.
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_unit
//
// Self-checking bench for branch_predict_unit (IDX_BITS=6, PEND_DEPTH=4).
// A transaction-level reference model (integer counters, a queue of pending
// predictions, a cycle budget for INIT) runs alongside every cycle. Directed
// vector tables and hand sequences add fixed expected values on top of it,
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_branch_predict_unit;

    localparam int ENTRIES = 64;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_target;
    logic        pred_ready;
    logic        pred_taken;
    logic        res_valid;
    logic        res_taken;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] mispredict_cnt;
    logic        protocol_err;

    always #5 clk = ~clk;

    branch_predict_unit #(.IDX_BITS(6), .PEND_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_target   (fetch_target),
        .pred_ready     (pred_ready),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .mispredict_cnt (mispredict_cnt),
        .protocol_err   (protocol_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc4;
        logic [31:0] tgt;
        int          idx;
        bit          pred;
    } pend_t;

    pend_t       m_q[$];
    int          m_ctr[ENTRIES];
    logic [31:0] m_cnt;
    logic [31:0] m_redir;
    bit          m_flush;
    bit          m_perr;
    int          m_init_left;
    bit          m_in_flush;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
        m_cnt       = '0;
        m_redir     = '0;
        m_flush     = 1'b0;
        m_perr      = 1'b0;
        m_init_left = ENTRIES;
        m_in_flush  = 1'b0;
    endtask

    // One clock cycle: drive inputs (called at posedge+1), sample the
    // combinational outputs, advance the clock, then compare registered
    // outputs against the model.
    task automatic cycle(input bit fv, input logic [31:0] pc, input logic [31:0] tgt,
                         input bit rv, input bit rt, output bit o_ready, output bit o_taken);
        bit    run, e_ready, e_taken, push;
        int    ix;
        pend_t h;
        pend_t n;
        fetch_valid  = fv;
        fetch_pc     = pc;
        fetch_target = tgt;
        res_valid    = rv;
        res_taken    = rt;
        #1;
        o_ready = pred_ready;
        o_taken = pred_taken;
        run     = (m_init_left == 0) && !m_in_flush;
        ix      = int'((pc >> 2) & 32'h3F);
        e_ready = run && (m_q.size() < DEPTH);
        e_taken = (m_ctr[ix] >= 2);
        check("model_pred_ready", o_ready, e_ready);
        if (run) check("model_pred_taken", o_taken, e_taken);

        @(posedge clk);
        #1;
        if (m_init_left > 0) begin
            m_init_left--;
            m_flush = 1'b0;
            m_perr  = 1'b0;
        end else if (m_in_flush) begin
            m_in_flush = 1'b0;
            m_flush    = 1'b0;
            m_perr     = 1'b0;
        end else begin
            push    = fv && e_ready;
            m_flush = 1'b0;
            m_perr  = rv && (m_q.size() == 0);
            if (rv && m_q.size() > 0) begin
                h = m_q.pop_front();
                if (rt) m_ctr[h.idx] = (m_ctr[h.idx] == 3) ? 3 : m_ctr[h.idx] + 1;
                else    m_ctr[h.idx] = (m_ctr[h.idx] == 0) ? 0 : m_ctr[h.idx] - 1;
                if (rt != h.pred) begin
                    m_flush    = 1'b1;
                    m_redir    = rt ? h.tgt : h.pc4;
                    m_cnt      = m_cnt + 32'd1;
                    m_q.delete();
                    push       = 1'b0;
                    m_in_flush = 1'b1;
                end
            end
            if (push) begin
                n.pc4  = pc + 32'd4;
                n.tgt  = tgt;
                n.idx  = ix;
                n.pred = e_taken;
                m_q.push_back(n);
            end
        end
        check("model_flush", flush, m_flush);
        check("model_redirect_pc", redirect_pc, m_redir);
        check("model_mispredict_cnt", mispredict_cnt, m_cnt);
        check("model_protocol_err", protocol_err, m_perr);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        fetch_valid  = 1'b0;
        fetch_pc     = '0;
        fetch_target = '0;
        res_valid    = 1'b0;
        res_taken    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flush", flush, 32'd0);
        check("reset_redirect_pc", redirect_pc, 32'd0);
        check("reset_mispredict_cnt", mispredict_cnt, 32'd0);
        check("reset_protocol_err", protocol_err, 32'd0);
        check("reset_pred_ready", pred_ready, 32'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    // INIT lasts ENTRIES cycles with pred_ready low, then every index
    // predicts not-taken.
    task automatic init_and_check();
        bit r, t;
        for (int k = 0; k < ENTRIES; k++) begin
            cycle(1'b1, 32'(k) << 2, 32'h0, 1'b1, 1'b1, r, t);
            check("init_pred_ready_low", r, 32'd0);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            cycle(1'b0, 32'(i) << 2, 32'h0, 1'b0, 1'b0, r, t);
            check("post_init_ready", r, 32'd1);
            check("post_init_pred_nt", t, 32'd0);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        bit          fv;
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          rv;
        bit          rt;
        bit          chk_tk;
        bit          e_ready;
        bit          e_taken;
        bit          e_flush;
        logic [31:0] e_redir;
        logic [31:0] e_cnt;
        bit          e_perr;
    } vec_t;

    function automatic vec_t mk(bit fv, bit rv, bit rt, bit chk_tk, bit e_ready, bit e_taken,
                                bit e_flush, logic [31:0] e_redir, logic [31:0] e_cnt, bit e_perr);
        vec_t v;
        v.fv = fv;  v.pc = 32'h100;  v.tgt = 32'h200;  v.rv = rv;  v.rt = rt;
        v.chk_tk = chk_tk;  v.e_ready = e_ready;  v.e_taken = e_taken;
        v.e_flush = e_flush;  v.e_redir = e_redir;  v.e_cnt = e_cnt;  v.e_perr = e_perr;
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit r, t;
        logic [31:0] pc, tgt;
        bit fv, rv, rt;

        // pc 0x100 -> idx 0, target 0x200. Counter trace: 01 -> 10 -> 11 -> 11
        // (saturated) -> 10 (mispredict on not-taken) -> 11.
        //             fv  rv  rt  ctk rdy tk  fl  redir        cnt  perr
        vecs[0]  = mk(1, 0, 0, 1, 1, 0, 0, 32'h000, 32'd0, 0);
        vecs[1]  = mk(0, 1, 1, 1, 1, 0, 1, 32'h200, 32'd1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h200, 32'd1, 0);
        vecs[3]  = mk(1, 0, 0, 1, 1, 1, 0, 32'h200, 32'd1, 0);
        vecs[4]  = mk(0, 1, 1, 1, 1, 1, 0, 32'h200, 32'd1, 0);
        vecs[5]  = mk(1, 0, 0, 1, 1, 1, 0, 32'h200, 32'd1, 0);
        vecs[6]  = mk(0, 1, 1, 1, 1, 1, 0, 32'h200, 32'd1, 0);
        vecs[7]  = mk(1, 0, 0, 1, 1, 1, 0, 32'h200, 32'd1, 0);
        vecs[8]  = mk(0, 1, 0, 1, 1, 1, 1, 32'h104, 32'd2, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h104, 32'd2, 0);
        vecs[10] = mk(1, 0, 0, 1, 1, 1, 0, 32'h104, 32'd2, 0);
        vecs[11] = mk(0, 1, 1, 1, 1, 1, 0, 32'h104, 32'd2, 0);
        vecs[12] = mk(0, 1, 1, 1, 1, 1, 0, 32'h104, 32'd2, 1);
        vecs[13] = mk(0, 0, 0, 1, 1, 1, 0, 32'h104, 32'd2, 0);

        do_reset();
        init_and_check();

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].fv, vecs[i].pc, vecs[i].tgt, vecs[i].rv, vecs[i].rt, r, t);
            check($sformatf("vec%0d_ready", i), r, vecs[i].e_ready);
            if (vecs[i].chk_tk) check($sformatf("vec%0d_taken", i), t, vecs[i].e_taken);
            check($sformatf("vec%0d_flush", i), flush, vecs[i].e_flush);
            check($sformatf("vec%0d_redirect", i), redirect_pc, vecs[i].e_redir);
            check($sformatf("vec%0d_cnt", i), mispredict_cnt, vecs[i].e_cnt);
            check($sformatf("vec%0d_perr", i), protocol_err, vecs[i].e_perr);
        end

        // Fill the FIFO: idx0 (ctr 11, pred 1), idx1..3 (ctr 01, pred 0).
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 32'h1000 + 32'(i * 4), 32'h5000, 1'b0, 1'b0, r, t);
            check("fill_ready", r, 32'd1);
        end
        cycle(1'b1, 32'h1010, 32'h5000, 1'b0, 1'b0, r, t);
        check("full_ready_low", r, 32'd0);
        // Full with a simultaneous correct pop: push still refused.
        cycle(1'b1, 32'h1010, 32'h5000, 1'b1, 1'b1, r, t);
        check("full_pop_ready_low", r, 32'd0);
        check("full_pop_no_flush", flush, 32'd0);
        cycle(1'b1, 32'h1010, 32'h5000, 1'b0, 1'b0, r, t);
        check("after_pop_ready", r, 32'd1);
        // Drain with correct not-taken resolves: no flush, count unchanged.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, r, t);
            check("drain_no_flush", flush, 32'd0);
            check("drain_cnt", mispredict_cnt, 32'd2);
        end

        // Three pending, head mispredicts not-taken with a same-cycle push.
        cycle(1'b1, 32'h2000, 32'h6000, 1'b0, 1'b0, r, t);
        check("mp_head_pred", t, 32'd1);
        cycle(1'b1, 32'h2004, 32'h6000, 1'b0, 1'b0, r, t);
        cycle(1'b1, 32'h2008, 32'h6000, 1'b0, 1'b0, r, t);
        cycle(1'b1, 32'h200c, 32'h6000, 1'b1, 1'b0, r, t);
        check("mp_flush", flush, 32'd1);
        check("mp_redirect", redirect_pc, 32'h2004);
        check("mp_cnt", mispredict_cnt, 32'd3);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, r, t);
        check("mp_flush_ready_low", r, 32'd0);
        check("mp_flush_one_cycle", flush, 32'd0);
        // FIFO must be empty: a resolve now is a protocol error.
        cycle(1'b0, 32'h2000, 32'h0, 1'b1, 1'b1, r, t);
        check("empty_perr", protocol_err, 32'd1);
        check("empty_no_flush", flush, 32'd0);
        cycle(1'b0, 32'h2000, 32'h0, 1'b0, 1'b0, r, t);
        check("perr_one_cycle", protocol_err, 32'd0);
        // idx0 went 11 -> 10 on the mispredict; the error must not touch it.
        check("perr_ctr_unchanged", t, 32'd1);

        // Reset with two pending, then INIT again and an empty FIFO.
        cycle(1'b1, 32'h3000, 32'h7000, 1'b0, 1'b0, r, t);
        cycle(1'b1, 32'h3004, 32'h7000, 1'b0, 1'b0, r, t);
        do_reset();
        init_and_check();
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, r, t);
        check("reset_fifo_empty_perr", protocol_err, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            fv  = ($urandom_range(0, 1) == 1);
            rv  = ($urandom_range(0, 9) < 4);
            rt  = ($urandom_range(0, 1) == 1);
            pc  = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FF1C);
            tgt = $urandom() & 32'hFFFF_FFFC;
            cycle(fv, pc, tgt, rv, rt, r, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
